trivium_prng_ctrl: RTL and testbench
====================================

# trivium_prng_ctrl

Sequencing controller for one `trivium_prng` instance. It accepts 160-bit seeds through a valid/ready handshake and loads them into the PRNG. It then runs a fixed warm-up whose output is discarded, and serves fresh randomness to a single consumer through a valid/ready handshake. An optional output budget forces a reseed after a configured number of words.

## Interface
- `RND`, 1: randomness width per word; must equal the PRNG instance's `RND`.
- `WARMUP_UPDATES`, 1152: number of discarded PRNG update cycles after each seed load. Must be ≥ 2. Integrators set it to ceil(1152/`RND`).
- `MAX_OUTPUTS`, 0: number of words served per seed before a reseed is required. 0 means unlimited.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: asynchronous reset, active low.
- `seed_valid` in 1: seed offer.
- `seed_ready` out 1: controller can accept a seed.
- `seed_key` in 80: key part of seed.
- `seed_iv` in 80: IV part of seed.
- `need_seed` out 1: no usable seed; high in IDLE and EXPIRED.
- `rnd_valid` out 1: `rnd_out` is a fresh word.
- `rnd_ready` in 1: consumer takes the word.
- `rnd_out` out `RND`: word, combinational pass-through of `prng_rnd`; glitchy, sample only at clock edges.
- `prng_key` out 80: registered key to PRNG.
- `prng_iv` out 80: registered IV to PRNG.
- `prng_feed_seed` out 1: PRNG seed load strobe.
- `prng_update` out 1: PRNG shift enable.
- `prng_rnd` in `RND`: PRNG output.

## Operation
- FSM states: IDLE, FEED, WARM, RUN, EXPIRED. Reset state is IDLE.
- Outputs are decoded from the state:
  - `seed_ready` = 1 in IDLE, RUN and EXPIRED; 0 in FEED and WARM.
  - `need_seed` = 1 in IDLE and EXPIRED.
  - `rnd_valid` = 1 only in RUN.
  - `prng_feed_seed` = 1 only in FEED.
  - `prng_update` = 1 in WARM, and in RUN when `rnd_ready` = 1 (combinational). Otherwise 0.
- Seed acceptance = `seed_valid & seed_ready`.
  - On acceptance, `seed_key` and `seed_iv` are registered into `prng_key` and `prng_iv`, and the next state is FEED.
  - The registers hold until the next acceptance.
- FEED lasts one cycle. It loads the warm-up counter with `WARMUP_UPDATES`-1 and goes to WARM.
- WARM counts the counter down by 1 per cycle, with `prng_update` = 1 every cycle. When the counter reaches 0, the next state is RUN. WARM therefore lasts exactly `WARMUP_UPDATES` cycles.
- Entering RUN clears the output counter.
- In RUN, a word transfers when `rnd_valid & rnd_ready`.
  - The same cycle's `prng_update` advances the PRNG, so the next word is available the following cycle.
  - With `MAX_OUTPUTS` > 0, the output counter increments per transfer. When a transfer makes the count equal `MAX_OUTPUTS`, the next state is EXPIRED.
- EXPIRED waits for a seed. An accepted seed goes to FEED.
- In RUN, when seed acceptance and a word transfer happen in the same cycle:
  - The word transfer completes.
  - Seed acceptance wins the state transition (next state FEED), even when the budget is reached on that transfer.
- Seed offers during FEED and WARM are not accepted. The upstream source holds `seed_valid`.
- Counter widths:
  - Warm-up counter: clog2(`WARMUP_UPDATES`).
  - Output counter: clog2(`MAX_OUTPUTS`+1). When `MAX_OUTPUTS` = 0 the output counter is absent or unused.
  - Neither counter wraps.

## Timing
- Asynchronous reset (`rst_n` low), taking effect immediately regardless of `clk`:
  - State IDLE; counters 0; `prng_key` and `prng_iv` = 0.
  - Outputs: `seed_ready` = 1, `need_seed` = 1, `rnd_valid` = 0, `prng_feed_seed` = 0, `prng_update` = 0.
- Reset mid-WARM or mid-RUN returns to IDLE. No word is valid until a new seed has completed warm-up.
- Seed accepted at edge k:
  - `prng_feed_seed` is high in cycle k+1.
  - `prng_update` is high in cycles k+2 .. k+1+`WARMUP_UPDATES`.
  - `rnd_valid` rises in cycle k+2+`WARMUP_UPDATES`.
- Throughput in RUN: one word per cycle while `rnd_ready` is held high.
- `rnd_valid` falls in the cycle after the budget-completing transfer or after a seed acceptance.

## Test plan
Benches use `WARMUP_UPDATES`=4, `MAX_OUTPUTS`=3, `RND`=1 unless stated.
- Reset, then hold `seed_valid`=0 → `seed_ready`=1, `need_seed`=1, `rnd_valid`=0, both prng strobes 0 for 20 cycles.
- Seed (key 0x0123456789ABCDEF0123, iv 0xFEDCBA98765432100123) accepted at cycle 0:
  - `prng_feed_seed` high in cycle 1 and `prng_key`/`prng_iv` match the seed.
  - `prng_update` high in cycles 2–5.
  - `rnd_valid` high from cycle 6.
  - The bit stream matches a golden Trivium model after 4 discarded updates.
- `rnd_ready` toggling 1,0,1,1 → exactly 3 transfers, `prng_update` high only on transfer cycles, then EXPIRED with `need_seed`=1 and `rnd_valid`=0.
- In RUN, `seed_valid`=1 and `rnd_ready`=1 in the same cycle → word consumed, `prng_feed_seed` high the next cycle, new warm-up of 4 cycles.
- `seed_valid` pulsed during WARM → `seed_ready`=0 and the registered key is unchanged; held until RUN → accepted there.
- `rst_n` dropped asynchronously mid-WARM → outputs immediately at reset values. `MAX_OUTPUTS`=0 variant → 1000 consecutive transfers with no expiry.

Source files
------------

// File: rtl/trivium_prng_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trivium_prng_ctrl
// Brief    : Seeds a trivium_prng, discards its warm-up output and serves
//            words to one consumer, with an optional per-seed output budget.
// Revision : 1.0 - initial release
// ============================================================================
module trivium_prng_ctrl #(
    parameter int RND            = 1,
    parameter int WARMUP_UPDATES = 1152,
    parameter int MAX_OUTPUTS    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            seed_valid,
    output logic            seed_ready,
    input  logic [79:0]     seed_key,
    input  logic [79:0]     seed_iv,
    output logic            need_seed,
    output logic            rnd_valid,
    input  logic            rnd_ready,
    output logic [RND-1:0]  rnd_out,
    output logic [79:0]     prng_key,
    output logic [79:0]     prng_iv,
    output logic            prng_feed_seed,
    output logic            prng_update,
    input  logic [RND-1:0]  prng_rnd
);

    localparam int c_WARM_W = $clog2(WARMUP_UPDATES);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_FEED    = 3'd1;
    localparam logic [2:0] c_WARM    = 3'd2;
    localparam logic [2:0] c_RUN     = 3'd3;
    localparam logic [2:0] c_EXPIRED = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_WARM_W-1:0] r_warm_cnt;
    logic [79:0]         r_key;
    logic [79:0]         r_iv;
    logic                w_seed_acc;
    logic                w_xfer;
    logic                w_out_last;
    logic                w_budget_hit;

    assign seed_ready     = (r_state == c_IDLE) || (r_state == c_RUN) ||
                            (r_state == c_EXPIRED);
    assign need_seed      = (r_state == c_IDLE) || (r_state == c_EXPIRED);
    assign rnd_valid      = (r_state == c_RUN);
    assign prng_feed_seed = (r_state == c_FEED);
    assign prng_update    = (r_state == c_WARM) || ((r_state == c_RUN) && rnd_ready);
    assign rnd_out        = prng_rnd;
    assign prng_key       = r_key;
    assign prng_iv        = r_iv;

    assign w_seed_acc   = seed_valid & seed_ready;
    assign w_xfer       = rnd_valid & rnd_ready;
    assign w_budget_hit = w_xfer & w_out_last;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (w_seed_acc) w_state_nxt = c_FEED;
            c_FEED:    w_state_nxt = c_WARM;
            c_WARM:    if (r_warm_cnt == '0) w_state_nxt = c_RUN;
            // A seed offered alongside the budget-completing word still wins.
            c_RUN: begin
                if (w_seed_acc)        w_state_nxt = c_FEED;
                else if (w_budget_hit) w_state_nxt = c_EXPIRED;
            end
            c_EXPIRED: if (w_seed_acc) w_state_nxt = c_FEED;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
            r_iv  <= '0;
        end else if (w_seed_acc) begin
            r_key <= seed_key;
            r_iv  <= seed_iv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm_cnt <= '0;
        end else if (r_state == c_FEED) begin
            r_warm_cnt <= c_WARM_W'(WARMUP_UPDATES - 1);
        end else if ((r_state == c_WARM) && (r_warm_cnt != '0)) begin
            r_warm_cnt <= r_warm_cnt - 1'b1;
        end
    end

    generate
        if (MAX_OUTPUTS > 0) begin : g_budget
            localparam int c_OUT_W = $clog2(MAX_OUTPUTS + 1);
            logic [c_OUT_W-1:0] r_out_cnt;

            // Held at zero outside RUN, so every entry into RUN starts fresh.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)                 r_out_cnt <= '0;
                else if (r_state != c_RUN)  r_out_cnt <= '0;
                else if (w_xfer)            r_out_cnt <= r_out_cnt + 1'b1;
            end

            assign w_out_last = (r_out_cnt == c_OUT_W'(MAX_OUTPUTS - 1));
        end else begin : g_unlimited
            assign w_out_last = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_trivium_prng_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trivium_prng_ctrl
// Brief    : Self-checking bench for trivium_prng_ctrl with a behavioural
//            Trivium stand-in and a word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trivium_prng_ctrl;

    localparam int c_RND = 1;
    localparam int c_WU  = 4;
    localparam int c_MAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_valid;
    logic        seed_ready;
    logic [79:0] seed_key;
    logic [79:0] seed_iv;
    logic        need_seed;
    logic        rnd_valid;
    logic        rnd_ready;
    logic [0:0]  rnd_out;
    logic [79:0] prng_key;
    logic [79:0] prng_iv;
    logic        prng_feed_seed;
    logic        prng_update;
    logic [0:0]  prng_rnd;

    logic        inf_seed_valid;
    logic        inf_seed_ready;
    logic        inf_need_seed;
    logic        inf_rnd_valid;
    logic        inf_rnd_ready;
    logic [0:0]  inf_rnd_out;
    logic [79:0] inf_prng_key;
    logic [79:0] inf_prng_iv;
    logic        inf_prng_feed_seed;
    logic        inf_prng_update;
    logic [0:0]  inf_prng_rnd;

    int n_checks = 0;
    int n_errors = 0;
    int n_xfer   = 0;
    int inf_xfer = 0;
    logic [0:0] sb_q[$];

    always #5 clk = ~clk;

    trivium_prng_ctrl #(.RND(c_RND), .WARMUP_UPDATES(c_WU), .MAX_OUTPUTS(c_MAX)) u_dut (
        .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed_ready(seed_ready),
        .seed_key(seed_key), .seed_iv(seed_iv), .need_seed(need_seed),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_out(rnd_out),
        .prng_key(prng_key), .prng_iv(prng_iv), .prng_feed_seed(prng_feed_seed),
        .prng_update(prng_update), .prng_rnd(prng_rnd)
    );

    trivium_prng_ctrl #(.RND(c_RND), .WARMUP_UPDATES(c_WU), .MAX_OUTPUTS(0)) u_dut_inf (
        .clk(clk), .rst_n(rst_n), .seed_valid(inf_seed_valid), .seed_ready(inf_seed_ready),
        .seed_key(seed_key), .seed_iv(seed_iv), .need_seed(inf_need_seed),
        .rnd_valid(inf_rnd_valid), .rnd_ready(inf_rnd_ready), .rnd_out(inf_rnd_out),
        .prng_key(inf_prng_key), .prng_iv(inf_prng_iv), .prng_feed_seed(inf_prng_feed_seed),
        .prng_update(inf_prng_update), .prng_rnd(inf_prng_rnd)
    );

    // Trivium reference: s_i is bit i-1, key bit i-1 is K_i, IV bit i-1 is IV_i.
    function automatic logic [287:0] triv_load(input logic [79:0] k, input logic [79:0] iv);
        logic [287:0] s;
        s = '0;
        for (int i = 0; i < 80; i++) begin
            s[i]      = k[i];
            s[93 + i] = iv[i];
        end
        s[285] = 1'b1;
        s[286] = 1'b1;
        s[287] = 1'b1;
        return s;
    endfunction

    function automatic logic triv_z(input logic [287:0] s);
        return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
    endfunction

    function automatic logic [287:0] triv_step(input logic [287:0] s);
        logic [287:0] n;
        logic t1, t2, t3;
        t1 = s[65]  ^ s[92]  ^ (s[90]  & s[91])  ^ s[170];
        t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
        t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
        n[0]       = t3;
        n[92:1]    = s[91:0];
        n[93]      = t1;
        n[176:94]  = s[175:93];
        n[177]     = t2;
        n[287:178] = s[286:177];
        return n;
    endfunction

    // Behavioural PRNG driven by the controller under test.
    logic [287:0] prng_st = '0;
    always @(posedge clk) begin
        if (prng_feed_seed)   prng_st <= triv_load(prng_key, prng_iv);
        else if (prng_update) prng_st <= triv_step(prng_st);
    end
    assign prng_rnd = triv_z(prng_st);

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic sr, input logic ns,
                            input logic v, input logic f, input logic u);
        chk({tag, ".seed_ready"}, 160'(seed_ready), 160'(sr));
        chk({tag, ".need_seed"},  160'(need_seed),  160'(ns));
        chk({tag, ".rnd_valid"},  160'(rnd_valid),  160'(v));
        chk({tag, ".feed_seed"},  160'(prng_feed_seed), 160'(f));
        chk({tag, ".update"},     160'(prng_update), 160'(u));
    endtask

    always @(negedge clk) begin
        if (rst_n && rnd_valid && rnd_ready) begin
            n_xfer++;
            if (sb_q.size() == 0) chk("sb_unexpected_word", 160'(1), 160'(0));
            else                  chk("word", 160'(rnd_out), 160'(sb_q.pop_front()));
        end
        if (rst_n && inf_rnd_valid && inf_rnd_ready) inf_xfer++;
    end

    task automatic push_word(inout logic [287:0] rs);
        sb_q.push_back(triv_z(rs));
        rs = triv_step(rs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0]  key1, iv1, key2, iv2, key3, iv3, key4;
        logic [287:0] ref_st;
        logic [3:0]   pat;
        int           bad;
        bit           seen;

        key1 = 80'h0123456789ABCDEF0123; iv1 = 80'hFEDCBA98765432100123;
        key2 = 80'h13579BDF02468ACE1111; iv2 = 80'h0F0F0F0F0F0F0F0F2222;
        key3 = 80'hA5A5A5A5A5A5A5A53333; iv3 = 80'h5A5A5A5A5A5A5A5A4444;
        key4 = 80'hDEADBEEFCAFEF00D5555;
        pat  = 4'b1101;

        rst_n = 1'b0; seed_valid = 1'b0; seed_key = '0; seed_iv = '0; rnd_ready = 1'b0;
        inf_seed_valid = 1'b0; inf_rnd_ready = 1'b0; inf_prng_rnd = 1'b0;
        #2;
        chk_outs("reset", 1, 1, 0, 0, 0);
        chk("reset.key", 160'(prng_key), 160'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            chk_outs("idle", 1, 1, 0, 0, 0);
        end

        // Seed 1, warm-up and a 1,0,1,1 consumer pattern into expiry.
        @(posedge clk); #1 seed_valid = 1'b1; seed_key = key1; seed_iv = iv1;
        #1 chk("seed1.ready", 160'(seed_ready), 160'(1));
        @(posedge clk); #1 seed_valid = 1'b0;
        #1 chk_outs("feed1", 0, 0, 0, 1, 0);
        chk("feed1.key", 160'(prng_key), 160'(key1));
        chk("feed1.iv",  160'(prng_iv),  160'(iv1));
        for (int i = 0; i < c_WU; i++) begin
            @(posedge clk); #2 chk_outs("warm1", 0, 0, 0, 0, 1);
        end
        ref_st = triv_load(key1, iv1);
        repeat (c_WU) ref_st = triv_step(ref_st);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 rnd_ready = pat[i];
            if (pat[i]) push_word(ref_st);
            #1 chk_outs("run1", 1, 0, 1, 0, pat[i]);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1 rnd_ready = 1'b1;
            #1 chk_outs("expired1", 1, 1, 0, 0, 0);
        end
        chk("run1.xfers", 160'(n_xfer), 160'(3));

        // Seed 2; a new seed offered during WARM waits and is taken in RUN
        // together with a word transfer.
        @(posedge clk); #1 rnd_ready = 1'b0; seed_valid = 1'b1; seed_key = key2; seed_iv = iv2;
        @(posedge clk); #1 seed_valid = 1'b0;
        #1 chk_outs("feed2", 0, 0, 0, 1, 0);
        chk("feed2.key", 160'(prng_key), 160'(key2));
        @(posedge clk); #2 chk_outs("warm2a", 0, 0, 0, 0, 1);
        @(posedge clk); #1 seed_valid = 1'b1; seed_key = key3; seed_iv = iv3;
        #1 chk_outs("warm2b", 0, 0, 0, 0, 1);
        @(posedge clk); #2 chk("warm2.key_held", 160'(prng_key), 160'(key2));
        chk_outs("warm2c", 0, 0, 0, 0, 1);
        @(posedge clk); #2 chk_outs("warm2d", 0, 0, 0, 0, 1);
        ref_st = triv_load(key2, iv2);
        repeat (c_WU) ref_st = triv_step(ref_st);
        @(posedge clk); #1 rnd_ready = 1'b1; push_word(ref_st);
        #1 chk_outs("run2_both", 1, 0, 1, 0, 1);
        @(posedge clk); #1 seed_valid = 1'b0; rnd_ready = 1'b0;
        #1 chk_outs("feed3", 0, 0, 0, 1, 0);
        chk("feed3.key", 160'(prng_key), 160'(key3));
        chk("feed3.iv",  160'(prng_iv),  160'(iv3));
        for (int i = 0; i < c_WU; i++) begin
            @(posedge clk); #2 chk_outs("warm3", 0, 0, 0, 0, 1);
        end

        // Seed 3: full budget again, so the output counter must restart.
        ref_st = triv_load(key3, iv3);
        repeat (c_WU) ref_st = triv_step(ref_st);
        for (int i = 0; i < c_MAX; i++) begin
            @(posedge clk); #1 rnd_ready = 1'b1; push_word(ref_st);
            #1 chk_outs("run3", 1, 0, 1, 0, 1);
        end
        @(posedge clk); #2 chk_outs("expired3", 1, 1, 0, 0, 0);

        // Seed 4 interrupted by an asynchronous reset in the middle of WARM.
        @(posedge clk); #1 rnd_ready = 1'b0; seed_valid = 1'b1; seed_key = key4;
        @(posedge clk); #1 seed_valid = 1'b0;
        @(posedge clk); #2 chk_outs("warm4", 0, 0, 0, 0, 1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1 chk_outs("async_rst", 1, 1, 0, 0, 0);
        chk("async_rst.key", 160'(prng_key), 160'(0));
        chk("async_rst.iv",  160'(prng_iv),  160'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2 chk_outs("post_rst", 1, 1, 0, 0, 0);
        end
        chk("sb.drained", 160'(sb_q.size()), 160'(0));
        chk("total.xfers", 160'(n_xfer), 160'(7));

        // Unlimited instance: 1000 back-to-back words, never expires.
        @(posedge clk); #1 inf_seed_valid = 1'b1; seed_key = key1; seed_iv = iv1;
        @(posedge clk); #1 inf_seed_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #2 if (inf_rnd_valid) seen = 1'b1;
        end
        chk("inf.reached_run", 160'(seen), 160'(1));
        chk("inf.key", 160'(inf_prng_key), 160'(key1));
        inf_rnd_ready = 1'b1;
        bad = 0;
        #1 if (!inf_prng_update) bad++;
        for (int i = 1; i < 1000; i++) begin
            @(posedge clk); #2;
            if (!inf_rnd_valid || inf_need_seed || !inf_prng_update) bad++;
        end
        @(negedge clk); #1 inf_rnd_ready = 1'b0;
        chk("inf.stalls", 160'(bad), 160'(0));
        chk("inf.xfers", 160'(inf_xfer), 160'(1000));
        @(posedge clk); #2 chk("inf.still_valid", 160'(inf_rnd_valid), 160'(1));
        chk("inf.no_update_idle", 160'(inf_prng_update), 160'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
